// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage access controller.
// State encodings are fixed so the state register can be observed directly in debug.
package mem_ctrl_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/mem_req_reg.sv
// Enable-gated capture of address, store word and direction for one memory transaction.
// Holds its contents whenever i_en is low, so the request stays stable while it is outstanding.
module mem_req_reg
    import mem_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_en,
    input  word_t i_addr,
    input  word_t i_wdata,
    input  logic  i_wr,
    output word_t o_addr,
    output word_t o_wdata,
    output logic  o_wr
);

    word_t r_addr;
    word_t r_wdata;
    logic  r_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
        end else if (i_en) begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_wr    <= i_wr;
        end
    end

    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_wr    = r_wr;

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage controller: turns a load/store into a req/busy/done memory transaction and stalls
// the pipeline until it completes (min 4 cycles); illegal accesses set a sticky err instead.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] Addr,
    input  logic [WORD_W-1:0] Store_Data,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              Stall,
    output logic [WORD_W-1:0] Read_Data,
    output logic              Valid_Out,
    output logic              err
);

    state_t r_state;
    state_t w_next;
    logic   w_legal;
    logic   w_illegal;
    logic   w_capture;
    logic   r_mem_req;
    word_t  r_read_data;
    logic   r_err;

    // Misaligned or conflicting requests never reach memory.
    assign w_legal   = (MemRead ^ MemWrite) & ~Addr[0];
    assign w_illegal = (MemRead | MemWrite) & ~w_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        Stall     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_legal) begin
                    w_capture = 1'b1;
                    Stall     = 1'b1;
                    w_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                Stall = 1'b1;
                if (!mem_busy) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                Stall = 1'b1;
                if (mem_done) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    mem_req_reg u_req_reg (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_capture),
        .i_addr  (Addr),
        .i_wdata (Store_Data),
        .i_wr    (MemWrite),
        .o_addr  (mem_addr),
        .o_wdata (mem_wdata),
        .o_wr    (mem_wr)
    );

    // Registered so mem_req is high exactly for the ISSUE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req <= 1'b0;
        end else begin
            r_mem_req <= (w_next == ST_ISSUE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_data <= '0;
        end else if ((r_state == ST_WAIT) && mem_done && !mem_wr) begin
            r_read_data <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign mem_req   = r_mem_req;
    assign Read_Data = r_read_data;
    assign Valid_Out = (r_state == ST_DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: inputs driven just after each falling edge, outputs sampled 1ns later.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] Addr;
    logic [15:0] Store_Data;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_busy;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        Stall;
    logic [15:0] Read_Data;
    logic        Valid_Out;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Addr       (Addr),
        .Store_Data (Store_Data),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .Stall      (Stall),
        .Read_Data  (Read_Data),
        .Valid_Out  (Valid_Out),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge; caller drives inputs, then waits #1 to sample.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Addr       = 16'h0000;
        Store_Data = 16'h0000;
        mem_busy   = 1'b0;
        mem_done   = 1'b0;
        mem_rdata  = 16'h0000;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1;
        idle_inputs();
        nxt();
        nxt();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_mem_req",   {15'd0, mem_req},   16'h0000);
        chk("rst_mem_wr",    {15'd0, mem_wr},    16'h0000);
        chk("rst_mem_addr",  mem_addr,           16'h0000);
        chk("rst_mem_wdata", mem_wdata,          16'h0000);
        chk("rst_read_data", Read_Data,          16'h0000);
        chk("rst_err",       {15'd0, err},       16'h0000);
        chk("rst_valid",     {15'd0, Valid_Out}, 16'h0000);
        chk("rst_stall",     {15'd0, Stall},     16'h0000);

        // Load 0x0010, done on first WAIT cycle
        nxt(); MemRead = 1'b1; Addr = 16'h0010; #1;
        chk("ld_c0_stall", {15'd0, Stall},   16'h0001);
        chk("ld_c0_req",   {15'd0, mem_req}, 16'h0000);
        nxt(); #1;
        chk("ld_c1_stall", {15'd0, Stall},   16'h0001);
        chk("ld_c1_req",   {15'd0, mem_req}, 16'h0001);
        chk("ld_c1_addr",  mem_addr,         16'h0010);
        chk("ld_c1_wr",    {15'd0, mem_wr},  16'h0000);
        nxt(); mem_done = 1'b1; mem_rdata = 16'hBEEF; #1;
        chk("ld_c2_stall", {15'd0, Stall},   16'h0001);
        chk("ld_c2_req",   {15'd0, mem_req}, 16'h0000);
        nxt(); mem_done = 1'b0; mem_rdata = 16'h0000; #1;
        chk("ld_c3_valid", {15'd0, Valid_Out}, 16'h0001);
        chk("ld_c3_stall", {15'd0, Stall},     16'h0000);
        chk("ld_c3_rdata", Read_Data,          16'hBEEF);
        nxt(); idle_inputs(); #1;
        chk("ld_c4_valid", {15'd0, Valid_Out}, 16'h0000);
        chk("ld_c4_stall", {15'd0, Stall},     16'h0000);

        // Store 0x1234 -> 0x0020, busy for 3 ISSUE cycles
        nxt(); MemWrite = 1'b1; Addr = 16'h0020; Store_Data = 16'h1234; mem_busy = 1'b1; #1;
        chk("st_c0_stall", {15'd0, Stall}, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            nxt(); mem_busy = (i < 3); #1;
            chk("st_issue_req",   {15'd0, mem_req}, 16'h0001);
            chk("st_issue_addr",  mem_addr,         16'h0020);
            chk("st_issue_wdata", mem_wdata,        16'h1234);
            chk("st_issue_wr",    {15'd0, mem_wr},  16'h0001);
            chk("st_issue_stall", {15'd0, Stall},   16'h0001);
        end
        nxt(); mem_busy = 1'b0; mem_done = 1'b1; mem_rdata = 16'hDEAD; #1;
        chk("st_c5_req",   {15'd0, mem_req},   16'h0000);
        chk("st_c5_valid", {15'd0, Valid_Out}, 16'h0000);
        nxt(); mem_done = 1'b0; #1;
        chk("st_c6_valid", {15'd0, Valid_Out}, 16'h0001);
        chk("st_c6_rdata", Read_Data,          16'hBEEF);
        nxt(); idle_inputs(); #1;
        chk("st_c7_valid", {15'd0, Valid_Out}, 16'h0000);

        // Misaligned load
        chk("mis_err_pre", {15'd0, err}, 16'h0000);
        nxt(); MemRead = 1'b1; Addr = 16'h0011; #1;
        chk("mis_stall", {15'd0, Stall}, 16'h0000);
        nxt(); idle_inputs(); #1;
        chk("mis_req", {15'd0, mem_req}, 16'h0000);
        chk("mis_err", {15'd0, err},     16'h0001);
        for (int i = 0; i < 10; i++) nxt();
        #1;
        chk("mis_err_sticky", {15'd0, err},     16'h0001);
        chk("mis_req_late",   {15'd0, mem_req}, 16'h0000);

        // Read and write together
        do_reset();
        chk("both_err_pre", {15'd0, err}, 16'h0000);
        nxt(); MemRead = 1'b1; MemWrite = 1'b1; Addr = 16'h0030; #1;
        chk("both_stall", {15'd0, Stall}, 16'h0000);
        nxt(); idle_inputs(); #1;
        chk("both_err", {15'd0, err},     16'h0001);
        chk("both_req", {15'd0, mem_req}, 16'h0000);

        // Back-to-back loads 0x0002 then 0x0004
        do_reset();
        nxt(); MemRead = 1'b1; Addr = 16'h0002; #1;
        nxt(); #1;
        chk("b2b_a_req", {15'd0, mem_req}, 16'h0001);
        chk("b2b_a_addr", mem_addr,        16'h0002);
        nxt(); mem_done = 1'b1; mem_rdata = 16'h1111; #1;
        nxt(); mem_done = 1'b0; #1;
        chk("b2b_a_valid", {15'd0, Valid_Out}, 16'h0001);
        chk("b2b_a_rdata", Read_Data,          16'h1111);
        nxt(); Addr = 16'h0004; #1;
        chk("b2b_b_accept_stall", {15'd0, Stall},   16'h0001);
        chk("b2b_b_accept_req",   {15'd0, mem_req}, 16'h0000);
        nxt(); #1;
        chk("b2b_b_req",  {15'd0, mem_req}, 16'h0001);
        chk("b2b_b_addr", mem_addr,         16'h0004);
        chk("b2b_b_hold", Read_Data,        16'h1111);
        nxt(); mem_done = 1'b1; mem_rdata = 16'h2222; #1;
        nxt(); mem_done = 1'b0; #1;
        chk("b2b_b_valid", {15'd0, Valid_Out}, 16'h0001);
        chk("b2b_b_rdata", Read_Data,          16'h2222);
        nxt(); idle_inputs(); #1;

        // Reset while in WAIT, then a late mem_done
        nxt(); MemRead = 1'b1; Addr = 16'h0008; #1;
        nxt(); #1;
        chk("rw_issue_req", {15'd0, mem_req}, 16'h0001);
        nxt(); #1;
        chk("rw_wait_stall", {15'd0, Stall}, 16'h0001);
        rst = 1'b1;
        nxt(); rst = 1'b0; idle_inputs(); mem_done = 1'b1; mem_rdata = 16'h5555; #1;
        chk("rw_req",   {15'd0, mem_req},   16'h0000);
        chk("rw_valid", {15'd0, Valid_Out}, 16'h0000);
        chk("rw_stall", {15'd0, Stall},     16'h0000);
        chk("rw_rdata", Read_Data,          16'h0000);
        nxt(); mem_done = 1'b0; mem_rdata = 16'h0000; #1;
        chk("rw_late_valid", {15'd0, Valid_Out}, 16'h0000);
        chk("rw_late_rdata", Read_Data,          16'h0000);
        chk("rw_late_req",   {15'd0, mem_req},   16'h0000);
        nxt(); #1;
        chk("rw_late2_valid", {15'd0, Valid_Out}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
